// File: rtl/zombie_wave_ctrl.sv
// Game-level controller for the zombie shooter: owns the alive mask, schedules
// spawns through a valid/ack handshake, applies kills and shooter damage, and
// tracks score, wave and health. Every output is a register.
module zombie_wave_ctrl #(
  parameter int NUM_ZOMBIES    = 10,
  parameter int SPAWN_INTERVAL = 60,
  parameter int WAVE_SIZE      = 10,
  parameter int IFRAMES        = 30,
  parameter int MAX_HEALTH     = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic [NUM_ZOMBIES-1:0] zombie_dead,
  input  logic                   shooter_take_damage,
  input  logic                   spawn_ack,
  output logic                   spawn_valid,
  output logic [3:0]             spawn_idx,
  output logic [NUM_ZOMBIES-1:0] zombie_alive,
  output logic [2:0]             health,
  output logic                   invincible,
  output logic [15:0]            score,
  output logic [7:0]             wave,
  output logic                   game_over
);

  localparam int TW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int SW = $clog2(WAVE_SIZE + 1);
  localparam int IW = $clog2(IFRAMES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SPAWN_INTERVAL - 1);
  localparam logic [SW-1:0] S_LAST = SW'(WAVE_SIZE);
  localparam logic [IW-1:0] I_INIT = IW'(IFRAMES);
  localparam logic [2:0]    H_INIT = 3'(MAX_HEALTH);

  typedef enum logic [1:0] {IDLE, PLAY, WAVE_DONE, GAME_OVER} state_t;

  state_t                 state, state_n;
  logic [TW-1:0]          timer, timer_n;
  logic [SW-1:0]          spawned, spawned_n;
  logic [IW-1:0]          icnt, icnt_n;
  logic                   valid_n, invincible_n, game_over_n;
  logic [3:0]             idx_n;
  logic [NUM_ZOMBIES-1:0] alive_n;
  logic [2:0]             health_n;
  logic [15:0]            score_n;
  logic [7:0]             wave_n;

  logic                   ack_fire, free_any;
  logic [3:0]             free_idx;
  logic [NUM_ZOMBIES-1:0] kill_mask, ack_mask;
  logic [4:0]             kill_cnt;
  logic [16:0]            score_sum;

  // Per-cycle helpers: effective kills, lowest free slot, slot being acked.
  always_comb begin
    ack_fire  = spawn_valid & spawn_ack;
    kill_mask = zombie_dead & zombie_alive;
    ack_mask  = '0;
    kill_cnt  = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < NUM_ZOMBIES; i++) begin
      ack_mask[i] = ack_fire && (spawn_idx == 4'(i));
      // a kill flag on the slot being spawned this cycle loses to the spawn
      if (ack_mask[i]) kill_mask[i] = 1'b0;
    end
    for (int i = 0; i < NUM_ZOMBIES; i++)
      kill_cnt = kill_cnt + {4'd0, kill_mask[i]};
    for (int i = NUM_ZOMBIES - 1; i >= 0; i--) begin
      if (!zombie_alive[i]) begin
        free_any = 1'b1;
        free_idx = 4'(i);
      end
    end
    score_sum = {1'b0, score} + {12'd0, kill_cnt};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    timer_n      = timer;
    spawned_n    = spawned;
    icnt_n       = icnt;
    valid_n      = spawn_valid;
    idx_n        = spawn_idx;
    alive_n      = zombie_alive;
    health_n     = health;
    invincible_n = invincible;
    score_n      = score;
    wave_n       = wave;
    game_over_n  = game_over;
    case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_n      = PLAY;
          timer_n      = '0;
          spawned_n    = '0;
          icnt_n       = '0;
          valid_n      = 1'b0;
          idx_n        = '0;
          alive_n      = '0;
          health_n     = H_INIT;
          invincible_n = 1'b0;
          score_n      = '0;
          wave_n       = 8'd1;
          game_over_n  = 1'b0;
        end
      end
      PLAY: begin
        alive_n = (zombie_alive & ~kill_mask) | ack_mask;
        score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (ack_fire) begin
          valid_n   = 1'b0;
          timer_n   = '0;
          spawned_n = spawned + 1'b1;
        end else begin
          // timer parks at its terminal value until a request can go out
          if (frame_tick && timer < T_LAST) timer_n = timer + 1'b1;
          if (!spawn_valid && timer == T_LAST && spawned < S_LAST && free_any) begin
            valid_n = 1'b1;
            idx_n   = free_idx;
          end
        end
        if (shooter_take_damage && !invincible) begin
          if (health <= 3'd1) begin
            health_n     = '0;
            state_n      = GAME_OVER;
            game_over_n  = 1'b1;
            alive_n      = '0;
            valid_n      = 1'b0;
            invincible_n = 1'b0;
            icnt_n       = '0;
          end else begin
            health_n     = health - 3'd1;
            invincible_n = 1'b1;
            icnt_n       = I_INIT;
          end
        end else if (invincible && frame_tick) begin
          if (icnt <= 1) begin
            icnt_n       = '0;
            invincible_n = 1'b0;
          end else begin
            icnt_n = icnt - 1'b1;
          end
        end
        if (state_n == PLAY && spawned_n == S_LAST && alive_n == '0)
          state_n = WAVE_DONE;
      end
      WAVE_DONE: begin
        wave_n    = (wave == 8'hFF) ? wave : wave + 8'd1;
        spawned_n = '0;
        timer_n   = '0;
        state_n   = PLAY;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      timer        <= '0;
      spawned      <= '0;
      icnt         <= '0;
      spawn_valid  <= 1'b0;
      spawn_idx    <= '0;
      zombie_alive <= '0;
      health       <= H_INIT;
      invincible   <= 1'b0;
      score        <= '0;
      wave         <= '0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      spawned      <= spawned_n;
      icnt         <= icnt_n;
      spawn_valid  <= valid_n;
      spawn_idx    <= idx_n;
      zombie_alive <= alive_n;
      health       <= health_n;
      invincible   <= invincible_n;
      score        <= score_n;
      wave         <= wave_n;
      game_over    <= game_over_n;
    end
  end

endmodule

// File: tb/tb_zombie_wave_ctrl.sv
// Directed bench for zombie_wave_ctrl: spawn handshake, kills, damage and
// i-frames, game over/restart, wave completion and reset mid-handshake.
`timescale 1ns/1ps
module tb_zombie_wave_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  zombie_dead = '0;
  logic        shooter_take_damage = 1'b0;
  logic        spawn_ack = 1'b0;
  logic        spawn_valid;
  logic [3:0]  spawn_idx;
  logic [9:0]  zombie_alive;
  logic [2:0]  health;
  logic        invincible;
  logic [15:0] score;
  logic [7:0]  wave;
  logic        game_over;

  int n_chk = 0;
  int n_err = 0;

  zombie_wave_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .zombie_dead(zombie_dead), .shooter_take_damage(shooter_take_damage),
    .spawn_ack(spawn_ack), .spawn_valid(spawn_valid), .spawn_idx(spawn_idx),
    .zombie_alive(zombie_alive), .health(health), .invincible(invincible),
    .score(score), .wave(wave), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n clock edges; inputs change and outputs are sampled 1ns after the edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic tick(input int n);
    frame_tick = 1'b1;
    cyc(n);
    frame_tick = 1'b0;
  endtask

  // run frame ticks until a spawn request appears (bounded)
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    frame_tick = 1'b1;
    while (!spawn_valid && n < 200) begin
      cyc(1);
      n++;
    end
    frame_tick = 1'b0;
    if (n >= 200) chk({tag, "_timeout"}, 32'(spawn_valid), 1);
  endtask

  task automatic ack1;
    spawn_ack = 1'b1;
    cyc(1);
    spawn_ack = 1'b0;
  endtask

  initial begin
    // reset
    cyc(2);
    Reset = 1'b0;
    chk("rst_valid", 32'(spawn_valid), 0);
    chk("rst_alive", 32'(zombie_alive), 0);
    chk("rst_health", 32'(health), 5);
    chk("rst_wave", 32'(wave), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_gover", 32'(game_over), 0);

    // 1: start, spawn interval boundary, first ack
    start = 1'b1; cyc(1); start = 1'b0;
    chk("start_wave", 32'(wave), 1);
    tick(59);
    chk("t1_valid_59", 32'(spawn_valid), 0);
    tick(1);
    chk("t1_valid_60", 32'(spawn_valid), 1);
    chk("t1_idx", 32'(spawn_idx), 0);
    ack1();
    chk("t1_alive", 32'(zombie_alive), 10'h001);
    chk("t1_valid_off", 32'(spawn_valid), 0);

    // 2: fill to 007, pending request must stay put without ack
    wait_req("t2a"); ack1();
    wait_req("t2b"); ack1();
    chk("t2_alive7", 32'(zombie_alive), 10'h007);
    wait_req("t2c");
    chk("t2_idx", 32'(spawn_idx), 3);
    cyc(2);
    tick(3);
    chk("t2_hold_valid", 32'(spawn_valid), 1);
    chk("t2_hold_idx", 32'(spawn_idx), 3);
    ack1();
    // ack with a kill flag on the same slot: slot still comes alive, no score
    wait_req("t2d");
    chk("t2_idx4", 32'(spawn_idx), 4);
    spawn_ack = 1'b1; zombie_dead = 10'h010;
    cyc(1);
    spawn_ack = 1'b0; zombie_dead = '0;
    chk("t2_ackkill_alive", 32'(zombie_alive), 10'h01F);
    chk("t2_ackkill_score", 32'(score), 0);

    // 3: trim to 005 then a held multi-bit kill flag counts once per live slot
    zombie_dead = 10'h01A; cyc(1); zombie_dead = '0;
    chk("t3_alive5", 32'(zombie_alive), 10'h005);
    chk("t3_score3", 32'(score), 3);
    zombie_dead = 10'h025;
    cyc(1);
    chk("t3_alive0", 32'(zombie_alive), 0);
    chk("t3_score5", 32'(score), 5);
    cyc(2);
    zombie_dead = '0;
    chk("t3_score_held", 32'(score), 5);

    // 4: damage held across the i-frame window
    shooter_take_damage = 1'b1;
    cyc(1);
    chk("t4_h4", 32'(health), 4);
    chk("t4_inv", 32'(invincible), 1);
    frame_tick = 1'b1;
    cyc(29);
    chk("t4_h4_held", 32'(health), 4);
    chk("t4_inv_29", 32'(invincible), 1);
    cyc(1);
    chk("t4_inv_clr", 32'(invincible), 0);
    chk("t4_h4_clr", 32'(health), 4);
    cyc(1);
    chk("t4_h3", 32'(health), 3);
    chk("t4_inv2", 32'(invincible), 1);
    frame_tick = 1'b0;
    shooter_take_damage = 1'b0;

    // 5: drain health to zero while a spawn request is pending
    tick(30);
    shooter_take_damage = 1'b1; cyc(1); shooter_take_damage = 1'b0;
    chk("t5_h2", 32'(health), 2);
    tick(30);
    shooter_take_damage = 1'b1; cyc(1); shooter_take_damage = 1'b0;
    chk("t5_h1", 32'(health), 1);
    tick(30);
    chk("t5_pending", 32'(spawn_valid), 1);
    shooter_take_damage = 1'b1; cyc(1); shooter_take_damage = 1'b0;
    chk("t5_h0", 32'(health), 0);
    chk("t5_gover", 32'(game_over), 1);
    chk("t5_valid", 32'(spawn_valid), 0);
    chk("t5_alive", 32'(zombie_alive), 0);
    chk("t5_inv", 32'(invincible), 0);
    chk("t5_score_held", 32'(score), 5);
    // game over ignores everything but start
    zombie_dead = 10'h3FF; shooter_take_damage = 1'b1; spawn_ack = 1'b1;
    tick(3);
    zombie_dead = '0; shooter_take_damage = 1'b0; spawn_ack = 1'b0;
    chk("t5_go_health", 32'(health), 0);
    chk("t5_go_valid", 32'(spawn_valid), 0);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("t5_rs_health", 32'(health), 5);
    chk("t5_rs_score", 32'(score), 0);
    chk("t5_rs_wave", 32'(wave), 1);
    chk("t5_rs_gover", 32'(game_over), 0);

    // 6: full wave of 10, then all killed -> one WAVE_DONE cycle
    for (int i = 0; i < 10; i++) begin
      wait_req("t6_req");
      chk("t6_idx", 32'(spawn_idx), 32'(i));
      ack1();
    end
    chk("t6_alive_full", 32'(zombie_alive), 10'h3FF);
    tick(70);
    chk("t6_no_11th", 32'(spawn_valid), 0);
    zombie_dead = 10'h3FF; cyc(1); zombie_dead = '0;
    chk("t6_alive0", 32'(zombie_alive), 0);
    chk("t6_score10", 32'(score), 10);
    chk("t6_wave_pre", 32'(wave), 1);
    cyc(1);
    chk("t6_wave2", 32'(wave), 2);
    cyc(1);
    chk("t6_wave_once", 32'(wave), 2);
    tick(60);
    chk("t6_w2_valid", 32'(spawn_valid), 1);
    chk("t6_w2_idx", 32'(spawn_idx), 0);
    Reset = 1'b1; cyc(1);
    chk("t6_rst_valid", 32'(spawn_valid), 0);
    chk("t6_rst_wave", 32'(wave), 0);
    chk("t6_rst_score", 32'(score), 0);
    Reset = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
